// File: rtl/gv_pkg.sv
// Shared game constants and note-lane helpers for the falling-note scroller.
package gv_pkg;

    localparam int          SPEED_W   = 23;
    localparam int          LANES     = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic [2:0] PLAY = 3'd2;
    localparam logic [2:0] DIFF = 3'd3;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        EASY     = 2'd1,
        MEDIUM   = 2'd2,
        HARD     = 2'd3
    } level_e;

    // Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
        logic [LANES-1:0] v;
        v       = '0;
        v[lane] = 1'b1;
        return v;
    endfunction

    // Level 0 falls through to the EASY rule.
    function automatic logic [LANES-1:0] spawn_bits(input logic [1:0] level,
                                                    input logic [15:0] l);
        logic [LANES-1:0] v;
        v = '0;
        case (level_e'(level))
            MEDIUM:  v = lane_onehot(l[1:0]);
            HARD:    v = (l[3:0] != 4'd0) ? l[3:0] : lane_onehot(l[5:4]);
            default: if (l[15]) v = lane_onehot(l[1:0]);
        endcase
        return v;
    endfunction

    function automatic logic [2:0] lane_count(input logic [LANES-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + 3'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/scroll_tick.sv
// Scroll period counter: emits a one-cycle tick every max(diff_speed,2) clocks while enabled.
module scroll_tick
    import gv_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               enable,
    input  logic               clear,
    input  logic [SPEED_W-1:0] diff_speed,
    output logic               tick
);

    logic [SPEED_W-1:0] cnt;
    logic [SPEED_W-1:0] reload;
    logic               primed;

    assign reload = (diff_speed < SPEED_W'(2)) ? SPEED_W'(1) : diff_speed - SPEED_W'(1);

    // primed marks that cnt holds a real countdown; straight out of reset it
    // does not, so the first PLAY cycle behaves as if cnt were already R.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt    <= '0;
            primed <= 1'b0;
            tick   <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            primed <= 1'b0;
            tick   <= 1'b0;
        end else if (!enable) begin
            cnt    <= reload;
            primed <= 1'b1;
            tick   <= 1'b0;
        end else if (!primed) begin
            cnt    <= reload - SPEED_W'(1);
            primed <= 1'b1;
            tick   <= 1'b0;
        end else if (cnt == '0) begin
            cnt  <= reload;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt - SPEED_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/note_scroller.sv
// Falling-note grid: spawns notes from an LFSR, scrolls them on each tick and scores lane hits.
module note_scroller
    import gv_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [2:0]           mode,
    input  logic [SPEED_W-1:0]   diff_speed,
    input  logic [1:0]           level,
    input  logic [LANES-1:0]     hit,
    output logic                 tick,
    output logic [4*ROWS-1:0]    grid,
    output logic                 hit_ok,
    output logic                 miss,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    localparam int SUM_W = CNT_W + 1;

    logic              play;
    logic              diff;
    logic              step;
    logic [15:0]       lfsr;
    logic [LANES-1:0]  row0;
    logic [LANES-1:0]  hit_vec;
    logic [LANES-1:0]  miss_vec;
    logic [LANES-1:0]  spawn;
    logic [4*ROWS-1:0] grid_nxt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [2:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + SUM_W'(b);
        if (s[CNT_W]) return '1;
        return s[CNT_W-1:0];
    endfunction

    assign play = (mode == PLAY);
    assign diff = (mode == DIFF);
    assign step = play & tick;

    scroll_tick u_scroll_tick (
        .clk        (clk),
        .n_rst      (n_rst),
        .enable     (play),
        .clear      (diff),
        .diff_speed (diff_speed),
        .tick       (tick)
    );

    // Hits are resolved on the pre-shift bottom row, so a hit note is never also a miss.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        row0     = '0;
        grid_nxt = grid;
        for (int l = 0; l < LANES; l++) row0[l] = grid[l*ROWS];
        hit_vec  = play ? (hit & row0) : '0;
        miss_vec = step ? (row0 & ~hit_vec) : '0;
        spawn    = spawn_bits(level, lfsr);
        for (int l = 0; l < LANES; l++) grid_nxt[l*ROWS] = row0[l] & ~hit_vec[l];
        if (step) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < ROWS - 1; r++) grid_nxt[l*ROWS + r] = grid[l*ROWS + r + 1];
                grid_nxt[l*ROWS + ROWS - 1] = spawn[l];
            end
        end
    end

    // DIFF restarts the round; any other non-PLAY mode leaves everything frozen.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grid     <= '0;
            lfsr     <= LFSR_SEED;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
        end else if (diff) begin
            grid     <= '0;
            lfsr     <= LFSR_SEED;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            hit_ok   <= 1'b0;
            miss     <= 1'b0;
        end else begin
            grid     <= grid_nxt;
            if (step) lfsr <= lfsr_next(lfsr);
            hit_cnt  <= sat_add(hit_cnt, lane_count(hit_vec));
            miss_cnt <= sat_add(miss_cnt, lane_count(miss_vec));
            hit_ok   <= |hit_vec;
            miss     <= |miss_vec;
        end
    end

endmodule

// File: tb/tb_note_scroller.sv
// Directed bench for note_scroller: tick spacing, spawn/scroll, hits, misses, saturation, modes, reset.
module tb_note_scroller;
    import gv_pkg::*;

    logic        clk;
    logic        n_rst;
    logic [2:0]  mode;
    logic [22:0] diff_speed;
    logic [1:0]  level;
    logic [3:0]  hit;
    logic        tick;
    logic [31:0] grid;
    logic        hit_ok;
    logic        miss;
    logic [7:0]  hit_cnt;
    logic [7:0]  miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    note_scroller #(.ROWS(8), .CNT_W(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .mode       (mode),
        .diff_speed (diff_speed),
        .level      (level),
        .hit        (hit),
        .tick       (tick),
        .grid       (grid),
        .hit_ok     (hit_ok),
        .miss       (miss),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] row0_of(input logic [31:0] g);
        return {g[24], g[16], g[8], g[0]};
    endfunction

    // Waits (bounded) for a negedge with tick high; n = negedges waited.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 64);
        if (!tick) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    // Presents h during the tick cycle, returns one negedge later with the shift applied.
    task automatic tick_step(input logic [3:0] h, output int lat);
        wait_tick(lat);
        hit = h;
        @(negedge clk);
        hit = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int ticks_seen;

        n_rst      = 1'b0;
        mode       = 3'd0;
        level      = 2'd2;
        diff_speed = 23'd5;
        hit        = '0;
        #12;
        check("rst_tick",     32'(tick),     32'd0);
        check("rst_grid",     grid,          32'd0);
        check("rst_hit_ok",   32'(hit_ok),   32'd0);
        check("rst_miss",     32'(miss),     32'd0);
        check("rst_hit_cnt",  32'(hit_cnt),  32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(negedge clk) n_rst = 1'b1;

        // Tick spacing, MEDIUM level.
        @(negedge clk) mode = PLAY;
        wait_tick(n); check("first_tick_lat", n, 32'd5);
        wait_tick(n); check("period5", n, 32'd5);
        diff_speed = 23'd8;
        wait_tick(n); check("period_pre_change", n, 32'd5);
        wait_tick(n); check("period8", n, 32'd8);
        diff_speed = 23'd0;
        wait_tick(n); check("period8_tail", n, 32'd8);
        wait_tick(n); check("period_speed0", n, 32'd2);
        diff_speed = 23'd1;
        wait_tick(n);
        wait_tick(n); check("period_speed1", n, 32'd2);
        wait_tick(n);
        @(negedge clk);
        check("medium_miss",     32'(miss),         32'd1);
        check("medium_miss_cnt", 32'(miss_cnt),     32'd1);
        check("medium_row0",     32'(row0_of(grid)), 32'b1000);

        // DIFF clears grid and counters.
        mode = DIFF;
        repeat (3) @(negedge clk);
        check("diff_grid",     grid,          32'd0);
        check("diff_miss_cnt", 32'(miss_cnt), 32'd0);
        check("diff_hit_cnt",  32'(hit_cnt),  32'd0);

        // Level 0 follows the EASY rule: spawn only when L[15]=1.
        level      = 2'd0;
        diff_speed = 23'd4;
        mode       = PLAY;
        tick_step(4'b0000, n);
        check("easy_lat",   n,    32'd4);
        check("easy_tick1", grid, 32'h0000_8000);
        tick_step(4'b0000, n);
        check("easy_tick2", grid, 32'h0000_4000);

        // HARD spawn and scroll from a fresh LFSR seed.
        mode = DIFF;
        repeat (2) @(negedge clk);
        level = 2'd3;
        mode  = PLAY;
        tick_step(4'b0000, n);
        check("hard_lat",   n,    32'd4);
        check("hard_tick1", grid, 32'h0000_0080);
        repeat (7) tick_step(4'b0000, n);
        check("hard_tick8_grid", grid,          32'h783C_9E4F);
        check("hard_tick8_miss", 32'(miss_cnt), 32'd0);

        // Pause: grid frozen, no ticks; resume after R+1 cycles.
        mode       = 3'd1;
        ticks_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (tick) ticks_seen++;
        end
        check("pause_ticks", ticks_seen, 32'd0);
        check("pause_grid",  grid,       32'h783C_9E4F);
        mode = PLAY;
        tick_step(4'b0000, n);
        check("resume_lat",      n,              32'd4);
        check("tick9_miss",      32'(miss),      32'd1);
        check("tick9_miss_cnt",  32'(miss_cnt),  32'd1);
        check("tick9_row0",      32'(row0_of(grid)), 32'b0011);
        tick_step(4'b0000, n);
        check("tick10_miss_cnt", 32'(miss_cnt),  32'd3);

        // Hit lane 2 on the bottom row, then a harmless hit on an empty lane.
        hit = 4'b0100;
        @(negedge clk) hit = '0;
        check("hit_cleared", 32'(grid[16]), 32'd0);
        check("hit_ok",      32'(hit_ok),   32'd1);
        check("hit_cnt1",    32'(hit_cnt),  32'd1);
        hit = 4'b1000;
        @(negedge clk) hit = '0;
        check("empty_hit_ok",   32'(hit_ok),        32'd0);
        check("empty_hit_cnt",  32'(hit_cnt),       32'd1);
        check("empty_hit_row0", 32'(row0_of(grid)), 32'b0011);

        repeat (4) tick_step(4'b0000, n);
        tick_step(4'b0000, n);
        check("tick15_miss",     32'(miss),          32'd1);
        check("tick15_miss_cnt", 32'(miss_cnt),      32'd16);
        check("tick15_row0",     32'(row0_of(grid)), 32'b0010);

        // Replay from a fresh round with hit[0] on the tick that drops lanes 0 and 3.
        mode = DIFF;
        repeat (2) @(negedge clk);
        mode = PLAY;
        repeat (14) tick_step(4'b0000, n);
        tick_step(4'b0001, n);
        check("coinc_hit_ok",   32'(hit_ok),        32'd1);
        check("coinc_miss",     32'(miss),          32'd1);
        check("coinc_hit_cnt",  32'(hit_cnt),       32'd1);
        check("coinc_miss_cnt", 32'(miss_cnt),      32'd16);
        check("coinc_row0",     32'(row0_of(grid)), 32'b0010);

        // Saturation: every HARD tick now misses at least one note.
        diff_speed = 23'd2;
        repeat (400) tick_step(4'b0000, n);
        check("sat_miss_cnt", 32'(miss_cnt), 32'd255);
        tick_step(4'b0000, n);
        check("sat_miss_strobe", 32'(miss),     32'd1);
        check("sat_no_wrap",     32'(miss_cnt), 32'd255);
        check("sat_hit_cnt",     32'(hit_cnt),  32'd1);

        // Asynchronous reset mid-period.
        diff_speed = 23'd4;
        tick_step(4'b0000, n);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("arst_tick",     32'(tick),     32'd0);
        check("arst_grid",     grid,          32'd0);
        check("arst_hit_ok",   32'(hit_ok),   32'd0);
        check("arst_miss",     32'(miss),     32'd0);
        check("arst_hit_cnt",  32'(hit_cnt),  32'd0);
        check("arst_miss_cnt", 32'(miss_cnt), 32'd0);
        @(negedge clk) n_rst = 1'b1;
        tick_step(4'b0000, n);
        check("arst_first_lat", n,    32'd4);
        check("arst_reseed",    grid, 32'h0000_0080);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
